// File: rtl/eth_frame_tx.sv
// Ethernet frame transmitter: 14-byte header, payload passthrough from upstream,
// zero-padding up to MIN_PAYLOAD and truncation beyond MAX_PAYLOAD.
module eth_frame_tx #(
  parameter logic [47:0] SRC_ADDR    = 48'h000000000000,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [47:0] dest_mac_i,
  input  logic [15:0] ethertype_i,
  output logic        busy_o,
  input  logic [7:0]  s_payload_tdata_i,
  input  logic        s_payload_tvalid_i,
  input  logic        s_payload_tlast_i,
  output logic        s_payload_tready_o,
  output logic [7:0]  tx_axis_mac_tdata_o,
  output logic        tx_axis_mac_tvalid_o,
  output logic        tx_axis_mac_tlast_o,
  input  logic        tx_axis_mac_tready_i,
  output logic [15:0] frames_sent_o,
  output logic        trunc_o
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, DROP} state_e;

  localparam logic [10:0] MIN_LAST = 11'(MIN_PAYLOAD - 1);
  localparam logic [10:0] MAX_LAST = 11'(MAX_PAYLOAD - 1);
  localparam logic [10:0] HDR_LAST = 11'd13;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [47:0] dest_q, dest_d;
  logic [15:0] etype_q, etype_d;
  logic [15:0] frames_q, frames_d;
  logic        trunc_q, trunc_d;

  logic [111:0] hdr;
  logic [7:0]   hdr_byte;
  logic [7:0]   tdata;
  logic         tvalid, tlast, s_ready;
  logic         tx_hs, in_hs;

  // Header laid out in network order; byte 0 is the most significant byte.
  always_comb begin
    hdr      = {dest_q, SRC_ADDR, etype_q};
    hdr_byte = '0;
    for (int unsigned i = 0; i < 14; i++) begin
      if (cnt_q == 11'(i)) hdr_byte = hdr[8*(13-i) +: 8];
    end
  end

  always_comb begin
    tdata   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    s_ready = 1'b0;
    case (state_q)
      HDR: begin
        tdata  = hdr_byte;
        tvalid = 1'b1;
      end
      PAYLOAD: begin
        tdata   = s_payload_tdata_i;
        tvalid  = s_payload_tvalid_i;
        s_ready = tx_axis_mac_tready_i;
        // Index MAX_LAST always ends the frame: either a natural last byte or a truncation.
        tlast   = (s_payload_tlast_i && (cnt_q >= MIN_LAST)) || (cnt_q == MAX_LAST);
      end
      PAD: begin
        tvalid = 1'b1;
        tlast  = (cnt_q == MIN_LAST);
      end
      DROP: s_ready = 1'b1;
      default: ;
    endcase
  end

  assign tx_hs = tvalid && tx_axis_mac_tready_i;
  assign in_hs = s_payload_tvalid_i && s_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    etype_d  = etype_q;
    frames_d = frames_q;
    trunc_d  = 1'b0;
    if (tx_hs && tlast) frames_d = frames_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          dest_d  = dest_mac_i;
          etype_d = ethertype_i;
          cnt_d   = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (tx_hs) begin
          if (cnt_q == HDR_LAST) begin
            cnt_d   = '0;
            state_d = PAYLOAD;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      PAYLOAD: begin
        if (tx_hs) begin
          cnt_d = cnt_q + 11'd1;
          if (s_payload_tlast_i) begin
            state_d = (cnt_q >= MIN_LAST) ? IDLE : PAD;
          end else if (cnt_q == MAX_LAST) begin
            state_d = DROP;
            trunc_d = 1'b1;
          end
        end
      end
      PAD: begin
        if (tx_hs) begin
          cnt_d = cnt_q + 11'd1;
          if (cnt_q == MIN_LAST) state_d = IDLE;
        end
      end
      DROP: begin
        if (in_hs && s_payload_tlast_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dest_q   <= '0;
      etype_q  <= '0;
      frames_q <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
      etype_q  <= etype_d;
      frames_q <= frames_d;
      trunc_q  <= trunc_d;
    end
  end

  assign busy_o               = (state_q != IDLE);
  assign s_payload_tready_o   = s_ready;
  assign tx_axis_mac_tdata_o  = tdata;
  assign tx_axis_mac_tvalid_o = tvalid;
  assign tx_axis_mac_tlast_o  = tlast;
  assign frames_sent_o        = frames_q;
  assign trunc_o              = trunc_q;

endmodule

// File: doc/eth_frame_tx.md
# eth_frame_tx

Ethernet frame transmitter on the MAC transmit AXI-stream. On a start request it sends one frame: destination MAC, its own source MAC, EtherType, then payload streamed from an upstream byte source. Short payloads are zero-padded to the Ethernet minimum, and oversize payloads are truncated. It is the transmit-side counterpart of the frame receiver. Both connect to the same tri-mode MAC byte interface.

## Interface
- SRC_ADDR, 48'h000000000000, this node's MAC, inserted as source address
- MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded
- MAX_PAYLOAD, 1500, maximum payload bytes forwarded; 1 ≤ MIN_PAYLOAD ≤ MAX_PAYLOAD ≤ 2047
- clk_i  in  1  sole clock
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  frame request; sampled only in IDLE
- dest_mac_i  in  48  destination MAC, latched at start
- ethertype_i  in  16  EtherType, latched at start
- busy_o  out  1  high in every state except IDLE
- s_payload_tdata_i  in  8  payload byte
- s_payload_tvalid_i  in  1  payload byte valid
- s_payload_tlast_i  in  1  last payload byte of this frame
- s_payload_tready_o  out  1  payload byte accepted when tvalid&&tready
- tx_axis_mac_tdata_o  out  8  frame byte to MAC
- tx_axis_mac_tvalid_o  out  1  frame byte valid
- tx_axis_mac_tlast_o  out  1  final byte of frame
- tx_axis_mac_tready_i  in  1  MAC accepts byte when tvalid&&tready
- frames_sent_o  out  16  count of completed frames; wraps at 2^16
- trunc_o  out  1  one-cycle pulse when a payload is truncated

## Operation
- States: IDLE, HDR, PAYLOAD, PAD, DROP.
- Byte counter: 11 bits. Header uses indices 0..13. Payload/pad uses payload index 0..MAX_PAYLOAD-1.
- IDLE
  - All outputs 0 except frames_sent_o.
  - On start_i: latch dest_mac_i and ethertype_i, clear the counter, go to HDR.
- HDR
  - tvalid=1. Bytes in network order: dest_mac[47:40] first through dest_mac[7:0], then SRC_ADDR[47:40]..[7:0], then ethertype[15:8], ethertype[7:0].
  - Counter advances only on the tx handshake. After byte 13 is handshaken, go to PAYLOAD with payload index 0.
- PAYLOAD (combinational passthrough)
  - tdata_o = s_payload_tdata_i, tvalid_o = s_payload_tvalid_i, s_payload_tready_o = tx_axis_mac_tready_i.
  - The index increments on each handshake.
  - On a handshaken byte with s_payload_tlast_i=1:
    - index+1 ≥ MIN_PAYLOAD: tlast_o=1 on that byte, go to IDLE.
    - otherwise: tlast_o=0, go to PAD.
  - On a handshaken byte without tlast where index == MAX_PAYLOAD-1: tlast_o=1 on that byte, pulse trunc_o the next cycle, go to DROP.
- PAD
  - tdata=0x00, tvalid=1, s_payload_tready_o=0.
  - tlast=1 on payload index MIN_PAYLOAD-1. Its handshake returns to IDLE.
- DROP
  - tvalid=0, s_payload_tready_o=1. Input bytes are discarded.
  - A handshaken input tlast returns to IDLE.
- frames_sent_o increments on every tx handshake with tlast_o=1.
- start_i outside IDLE is ignored; no queuing.
- An empty payload is not supported. Upstream always supplies at least one byte with tlast.

## Timing
- Reset: state IDLE, counter 0, latched fields 0, frames_sent_o 0.
  - All outputs are 0 during reset and in the cycle after release.
- start_i high in IDLE at edge N:
  - busy_o and tvalid_o go high after edge N.
  - Dest byte 0 is presented until the first handshake.
- AXI rule: while tvalid_o=1 and tready_i=0, tdata/tlast hold stable in HDR and PAD. In PAYLOAD, stability is upstream's obligation.
- Minimum frame: 14 header + MIN_PAYLOAD beats with tready_i held high.
- After the tlast handshake the block is in IDLE next cycle. start_i may be accepted in that same cycle, giving one idle cycle between frames.
- Asynchronous reset mid-frame:
  - Outputs drop immediately without tlast and the frame is abandoned.
  - frames_sent_o clears.
- The MAC deasserting tready_i during PAYLOAD stalls upstream through the passthrough, so no byte is lost or duplicated.

## Test plan
- **Padded frame:** start with dest 0x010101010101 and type 0x0800, 4 payload bytes A0..A3, tready=1.
  - Expect 14 header bytes 01×6, 00×6, 08, 00.
  - Then A0..A3, then 42 × 0x00, tlast on beat 60; frames_sent_o=1.
- **Exact minimum:** 46-byte payload ending in tlast.
  - Expect tlast on the 46th payload byte, no pad, 60 beats total.
- **Truncation:** MAX_PAYLOAD=64, 100-byte payload.
  - Expect 64 payload beats, tlast on beat 78, trunc_o one pulse.
  - The 36 remaining input bytes are consumed with tvalid_o=0; then IDLE.
- **Backpressure:** tready toggles with a 1-in-3 pattern across header, payload and pad.
  - Byte sequence is identical to the unstalled run.
  - tdata stays stable while stalled; beat count is unchanged.
- **Start while busy:** pulse start_i mid-payload with a different dest.
  - The current frame is unaffected and no second frame is sent.
  - The next start in IDLE uses the new dest.
- **Reset mid-header:** assert rst_i after dest byte 3.
  - Outputs go 0 immediately and frames_sent_o=0.
  - After release, a new start yields a complete, correct frame.
